// File: rtl/i2c_target_responder.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte-wide write sink and read source; SDA driven only as an open-drain pull-low.
module i2c_target_responder #(
   parameter logic [6:0] DEVICE_ADDR = 7'h51,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       Reset,
   input  logic       SCL,
   input  logic       SDAIn,
   output logic       SDAPullLow,
   input  logic [7:0] TxData,
   output logic       TxRequest,
   output logic [7:0] RxData,
   output logic       RxValid,
   output logic       Busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_evt, stop_evt;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic       rw_q, rw_d;
   logic       ack_q, ack_d;
   logic       pull_q, pull_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       busy_q, busy_d;
   logic       tx_req;

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   // SDA edges only count as bus conditions when SCL was steadily high
   assign start_evt = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_evt  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

   always_ff @(posedge clock) begin
      if (Reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         shreg_q    <= 8'd0;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         pull_q     <= 1'b0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDAIn};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         pull_q     <= pull_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      rw_d       = rw_q;
      ack_d      = ack_q;
      pull_d     = pull_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req     = 1'b0;

      if (start_evt) begin
         state_d = ST_ADDR;
         cnt_d   = 4'd0;
         pull_d  = 1'b0;
         ack_d   = 1'b0;
      end else if (stop_evt) begin
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
         pull_d  = 1'b0;
         ack_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (scl_rise && cnt_q != 4'd8) begin
                  shreg_d = {shreg_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  if (shreg_q[7:1] == DEVICE_ADDR) begin
                     pull_d  = 1'b1;
                     rw_d    = shreg_q[0];
                     state_d = ST_ADDR_ACK;
                  end else begin
                     state_d = ST_WAIT_STOP;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_d = 4'd0;
                  if (rw_q) begin
                     tx_req  = 1'b1;
                     shreg_d = TxData;
                     pull_d  = ~TxData[7];
                     state_d = ST_RD_DATA;
                  end else begin
                     pull_d  = 1'b0;
                     state_d = ST_WR_DATA;
                  end
               end
            end
            ST_WR_DATA: begin
               if (scl_rise && cnt_q != 4'd8) begin
                  shreg_d = {shreg_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     rx_data_d  = {shreg_q[6:0], sda_s};
                     rx_valid_d = 1'b1;
                  end
               end else if (scl_fall && cnt_q == 4'd8) begin
                  pull_d  = 1'b1;
                  state_d = ST_WR_ACK;
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  pull_d  = 1'b0;
                  cnt_d   = 4'd0;
                  state_d = ST_WR_DATA;
               end
            end
            ST_RD_DATA: begin
               if (scl_rise && cnt_q != 4'd8) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  pull_d  = 1'b0;
                  cnt_d   = 4'd0;
                  ack_d   = 1'b0;
                  state_d = ST_RD_ACK;
               end else if (scl_fall && cnt_q != 4'd0) begin
                  shreg_d = {shreg_q[6:0], 1'b0};
                  pull_d  = ~shreg_q[6];
               end
            end
            ST_RD_ACK: begin
               // NACK ends the transfer at the sampling edge; ACK reloads on the fall
               if (scl_rise) begin
                  if (sda_s) state_d = ST_WAIT_STOP;
                  else       ack_d   = 1'b1;
               end else if (scl_fall && ack_q) begin
                  tx_req  = 1'b1;
                  shreg_d = TxData;
                  pull_d  = ~TxData[7];
                  ack_d   = 1'b0;
                  state_d = ST_RD_DATA;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d == ST_ADDR_ACK) || (state_d == ST_WR_DATA) ||
               (state_d == ST_WR_ACK)   || (state_d == ST_RD_DATA) ||
               (state_d == ST_RD_ACK);
   end

   assign SDAPullLow = pull_q;
   assign TxRequest  = tx_req & ~Reset;
   assign RxData     = rx_data_q;
   assign RxValid    = rx_valid_q;
   assign Busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench: behavioural I2C master with open-drain bus, checking the
// target's ACKs, read data, byte interface pulses and reset behaviour.
module tb_i2c_target_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_m;
   logic       pull;
   logic [7:0] tx_data;
   logic       tx_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       bus_sda;

   int checks   = 0;
   int failures = 0;
   int rxv_cnt  = 0;
   int txr_cnt  = 0;
   int pull_cyc = 0;

   assign bus_sda = sda_m & ~pull;

   always #5 clk = ~clk;

   i2c_target_responder #(.DEVICE_ADDR(7'h51), .SYNC_STAGES(2)) dut (
      .clock     (clk),
      .Reset     (rst),
      .SCL       (scl),
      .SDAIn     (bus_sda),
      .SDAPullLow(pull),
      .TxData    (tx_data),
      .TxRequest (tx_req),
      .RxData    (rx_data),
      .RxValid   (rx_valid),
      .Busy      (busy)
   );

   always @(posedge clk) begin
      if (rx_valid) rxv_cnt <= rxv_cnt + 1;
      if (tx_req)   txr_cnt <= txr_cnt + 1;
      if (pull)     pull_cyc <= pull_cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one SCL period: 8 clocks low (data set mid-low), 8 clocks high (sampled mid-high)
   task automatic bit_cycle(input logic b, input logic rst_mid,
                            output logic seen, output logic pull_seen);
      tick(4);
      sda_m = b;
      tick(4);
      scl = 1'b1;
      tick(4);
      seen      = bus_sda;
      pull_seen = pull;
      if (rst_mid) begin
         rst = 1'b1;
         tick(1);
         check_eq("rst_mid_pull", pull, 0);
         check_eq("rst_mid_busy", busy, 0);
         check_eq("rst_mid_rxdata", rx_data, 0);
         check_eq("rst_mid_pulses", {rx_valid, tx_req}, 0);
         rst = 1'b0;
         tick(3);
      end else begin
         tick(4);
      end
      scl = 1'b0;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      tick(4);
      scl = 1'b1;
      tick(8);
      sda_m = 1'b0;
      tick(8);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      tick(4);
      scl = 1'b1;
      tick(8);
      sda_m = 1'b1;
      tick(8);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack_pull, output logic data_pull);
      logic s, p;
      data_pull = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(b[i], 1'b0, s, p);
         data_pull |= p;
      end
      bit_cycle(1'b1, 1'b0, s, ack_pull);
   endtask

   task automatic read_byte(input logic nack, input logic [7:0] next_tx,
                            output logic [7:0] d, output logic ack_pull);
      logic s, p;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, 1'b0, s, p);
         d[i] = s;
      end
      tx_data = next_tx;
      bit_cycle(nack, 1'b0, s, ack_pull);
   endtask

   initial begin
      logic       a, dp, s, p;
      logic [7:0] d;
      int         rx0, tx0, pc0;

      rst = 1'b1; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
      tick(4);
      check_eq("reset_outputs", {pull, tx_req, rx_valid, busy}, 0);
      check_eq("reset_rxdata", rx_data, 0);
      rst = 1'b0;
      tick(10);

      // write 0x3C
      rx0 = rxv_cnt;
      i2c_start();
      send_byte(8'hA2, a, dp);
      check_eq("wr_addr_ack", a, 1);
      check_eq("wr_busy", busy, 1);
      send_byte(8'h3C, a, dp);
      check_eq("wr_data_ack", a, 1);
      check_eq("wr_data_nodrive", dp, 0);
      check_eq("wr_rxdata", rx_data, 8'h3C);
      check_eq("wr_rxvalid_once", rxv_cnt - rx0, 1);
      i2c_stop();
      tick(8);
      check_eq("wr_busy_stop", busy, 0);
      $display("txn write addr=0xA2 data=0x3C rx=0x%0h", rx_data);

      // address miss
      rx0 = rxv_cnt; pc0 = pull_cyc;
      i2c_start();
      send_byte(8'hA0, a, dp);
      check_eq("miss_busy", busy, 0);
      send_byte(8'h55, a, dp);
      i2c_stop();
      tick(8);
      check_eq("miss_no_pull", pull_cyc - pc0, 0);
      check_eq("miss_no_rxvalid", rxv_cnt - rx0, 0);
      check_eq("miss_busy_end", busy, 0);
      $display("txn miss addr=0xA0");

      // single-byte read with NACK
      tx0 = txr_cnt; tx_data = 8'h96;
      i2c_start();
      send_byte(8'hA3, a, dp);
      check_eq("rd_addr_ack", a, 1);
      read_byte(1'b1, 8'h00, d, p);
      check_eq("rd_data", d, 8'h96);
      check_eq("rd_ack_released", p, 0);
      check_eq("rd_txreq_once", txr_cnt - tx0, 1);
      check_eq("rd_busy_nack", busy, 0);
      pc0 = pull_cyc;
      i2c_stop();
      tick(8);
      check_eq("rd_no_pull_after_nack", pull_cyc - pc0, 0);
      $display("txn read addr=0xA3 data=0x%0h", d);

      // two-byte read: ACK then NACK
      tx0 = txr_cnt; tx_data = 8'h5A;
      i2c_start();
      send_byte(8'hA3, a, dp);
      read_byte(1'b0, 8'hC3, d, p);
      check_eq("rd2_byte0", d, 8'h5A);
      check_eq("rd2_busy_mid", busy, 1);
      read_byte(1'b1, 8'h00, d, p);
      check_eq("rd2_byte1", d, 8'hC3);
      check_eq("rd2_txreq_twice", txr_cnt - tx0, 2);
      i2c_stop();
      tick(8);
      $display("txn read2 addr=0xA3 last=0x%0h", d);

      // repeated START after a partial write byte
      rx0 = rxv_cnt; tx0 = txr_cnt; tx_data = 8'h96;
      i2c_start();
      send_byte(8'hA2, a, dp);
      for (int i = 0; i < 4; i++) bit_cycle(1'b0, 1'b0, s, p);
      i2c_start();
      send_byte(8'hA3, a, dp);
      check_eq("rs_addr_ack", a, 1);
      read_byte(1'b1, 8'h00, d, p);
      check_eq("rs_rd_data", d, 8'h96);
      check_eq("rs_no_rxvalid", rxv_cnt - rx0, 0);
      check_eq("rs_rxdata_kept", rx_data, 8'h3C);
      check_eq("rs_txreq_once", txr_cnt - tx0, 1);
      i2c_stop();
      tick(8);
      $display("txn restart partial-write then read data=0x%0h", d);

      // reset during the address ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) bit_cycle(((8'hA2 >> i) & 8'h01) != 0, 1'b0, s, p);
      bit_cycle(1'b1, 1'b1, s, p);
      check_eq("rst_ack_was_driving", p, 1);
      i2c_stop();
      tick(8);
      $display("txn reset during address ACK");

      // reset during read bit 3 (a 0 bit, so SDA is being pulled)
      tx_data = 8'h96;
      i2c_start();
      send_byte(8'hA3, a, dp);
      for (int i = 0; i < 4; i++) bit_cycle(1'b1, 1'b0, s, p);
      bit_cycle(1'b1, 1'b1, s, p);
      check_eq("rst_rd_was_driving", p, 1);
      i2c_stop();
      tick(8);
      i2c_start();
      send_byte(8'hA2, a, dp);
      check_eq("post_rst_addr_ack", a, 1);
      i2c_stop();
      tick(8);
      check_eq("post_rst_busy", busy, 0);
      $display("txn reset during read bit 3, then write addr ACK=%0d", a);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
